adc_sample_capture: RTL and testbench

- Receive side of the quad-ADC encode interface. Watches the encode clock that the encode clock generator drives to the ADC, and latches the parallel multi-channel ADC data bus once per encode period.
- Discards the ADC pipeline-latency samples after each enable, buffers valid samples in a FIFO, and presents them on a valid/ready stream to the downstream AXI logic.
- Lives entirely in the AXI clock domain.

---
 rtl/adc_capture_pkg.sv | 25 ++
 rtl/adc_sample_capture_if.sv | 22 ++
 rtl/adc_sample_fifo.sv | 86 ++++++++
 rtl/adc_sample_capture.sv | 141 ++++++++++++++
 tb/tb_adc_sample_capture.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types and width helpers for the ADC sample capture block.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } cap_state_e;

  localparam int unsigned SAMPLE_COUNT_W = 32;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Counter wide enough to hold 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/adc_sample_capture_if.sv
// Valid/ready sample stream between the capture block and downstream AXI logic.
interface adc_sample_capture_if #(
  parameter int unsigned WIDTH = 64
) ();

  logic [WIDTH-1:0] SAMPLE_DATA;
  logic             SAMPLE_VALID;
  logic             SAMPLE_READY;

  modport master (
    output SAMPLE_DATA,
    output SAMPLE_VALID,
    input  SAMPLE_READY
  );

  modport slave (
    input  SAMPLE_DATA,
    input  SAMPLE_VALID,
    output SAMPLE_READY
  );

endinterface

// File: rtl/adc_sample_fifo.sv
// Single-clock FIFO with a registered head word; a write into a full FIFO is
// accepted when a read pops the head in the same cycle.
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter  int unsigned WIDTH   = 64,
  parameter  int unsigned DEPTH   = 16,
  localparam int unsigned PTR_W   = ptr_width(DEPTH),
  localparam int unsigned LEVEL_W = level_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level,
  output logic               wr_accept_c
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   head_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_nx;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_nx;
  logic               full_q;
  logic               empty_q;
  logic               do_rd_c;
  logic               do_wr_c;

  assign do_rd_c     = rd_en && !empty_q;
  assign do_wr_c     = wr_en && (!full_q || do_rd_c);
  assign wr_accept_c = do_wr_c;
  assign rd_ptr_nx   = do_rd_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    level_nx = level_q;
    if (do_wr_c && !do_rd_c) begin
      level_nx = level_q + LEVEL_W'(1);
    end else if (do_rd_c && !do_wr_c) begin
      level_nx = level_q - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Head register looks ahead to the post-edge read pointer, bypassing a
  // word that is being written into that very slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      if (do_wr_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_nx;
      level_q  <= level_nx;
      full_q   <= (level_nx == LEVEL_W'(DEPTH));
      empty_q  <= (level_nx == '0);
      head_q   <= (do_wr_c && (wr_ptr_q == rd_ptr_nx)) ? wr_data : mem_q[rd_ptr_nx];
    end
  end

  assign rd_data = head_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

endmodule

// File: rtl/adc_sample_capture.sv
// Latches the quad-ADC bus on each encode-clock falling edge, drops the
// conversion-latency samples after enable and streams the rest out of a FIFO.
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH       = 16,
  parameter  int unsigned NUM_CHANNELS     = 4,
  parameter  int unsigned FIFO_DEPTH       = 16,
  parameter  int unsigned PIPELINE_LATENCY = 5,
  localparam int unsigned BUS_W            = NUM_CHANNELS * DATA_WIDTH,
  localparam int unsigned LEVEL_W          = level_width(FIFO_DEPTH)
) (
  input  logic                      AXI_CLK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic                      ENCODE_CLK,
  input  logic [BUS_W-1:0]          ADC_DATA,
  adc_sample_capture_if.master      stream,
  output logic [LEVEL_W-1:0]        FIFO_LEVEL,
  output logic                      OVERFLOW,
  input  logic                      CLEAR_OVERFLOW,
  output logic [SAMPLE_COUNT_W-1:0] SAMPLE_COUNT
);

  localparam int unsigned FLUSH_W = count_width(PIPELINE_LATENCY);

  cap_state_e          state_q;
  cap_state_e          state_nx;
  logic [FLUSH_W-1:0]  flush_cnt_q;
  logic                enc_d_q;
  logic                cap_c;
  logic                flush_done_c;
  logic                flush_inc_c;
  logic                flush_clr_c;
  logic                wr_req_c;
  logic                wr_accept_c;
  logic                drop_c;
  logic                overflow_q;
  logic [SAMPLE_COUNT_W-1:0] sample_count_q;
  logic [BUS_W-1:0]    fifo_rd_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LEVEL_W-1:0]  fifo_level;

  // Falling edge of the encode clock: ADC data is mid-stable here.
  assign cap_c        = !ENCODE_CLK && enc_d_q;
  assign flush_done_c = ((32'(flush_cnt_q) + 32'd1) == 32'(PIPELINE_LATENCY));
  assign drop_c       = wr_req_c && !wr_accept_c;

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    if (!ENABLE) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_nx = (PIPELINE_LATENCY == 0) ? ST_RUN : ST_FLUSH;
        ST_FLUSH: if (cap_c && flush_done_c) state_nx = ST_RUN;
        ST_RUN:   state_nx = ST_RUN;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    flush_inc_c = 1'b0;
    flush_clr_c = (state_q == ST_IDLE);
    wr_req_c    = 1'b0;
    if (ENABLE) begin
      unique case (state_q)
        ST_FLUSH: flush_inc_c = cap_c;
        ST_RUN:   wr_req_c    = cap_c;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      enc_d_q     <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      enc_d_q <= ENCODE_CLK;
      if (flush_clr_c) begin
        flush_cnt_q <= '0;
      end else if (flush_inc_c) begin
        flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
      end
    end
  end

  // A new drop outranks a coincident clear.
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      overflow_q     <= 1'b0;
      sample_count_q <= '0;
    end else begin
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (CLEAR_OVERFLOW) begin
        overflow_q <= 1'b0;
      end
      if (wr_accept_c) begin
        sample_count_q <= sample_count_q + SAMPLE_COUNT_W'(1);
      end
    end
  end

  adc_sample_fifo #(
    .WIDTH (BUS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (AXI_CLK),
    .rst         (RESET),
    .wr_en       (wr_req_c),
    .wr_data     (ADC_DATA),
    .rd_en       (stream.SAMPLE_READY),
    .rd_data     (fifo_rd_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .level       (fifo_level),
    .wr_accept_c (wr_accept_c)
  );

  assign stream.SAMPLE_DATA  = fifo_rd_data;
  assign stream.SAMPLE_VALID = !fifo_empty;
  assign FIFO_LEVEL          = fifo_level;
  assign OVERFLOW            = overflow_q;
  assign SAMPLE_COUNT        = sample_count_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed plus randomized bench for adc_sample_capture against a queue-based
// reference model of the capture/flush/FIFO rules.
module tb_adc_sample_capture;

  localparam int unsigned DW    = 16;
  localparam int unsigned NC    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 5;
  localparam int unsigned BW    = DW * NC;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          enc;
  logic          clr;
  logic [BW-1:0] adc;
  logic [LW-1:0] lvl;
  logic          ovf;
  logic [31:0]   cnt;

  adc_sample_capture_if #(.WIDTH(BW)) s_if ();

  adc_sample_capture #(
    .DATA_WIDTH       (DW),
    .NUM_CHANNELS     (NC),
    .FIFO_DEPTH       (DEPTH),
    .PIPELINE_LATENCY (LAT)
  ) dut (
    .AXI_CLK        (clk),
    .RESET          (rst),
    .ENABLE         (en),
    .ENCODE_CLK     (enc),
    .ADC_DATA       (adc),
    .stream         (s_if),
    .FIFO_LEVEL     (lvl),
    .OVERFLOW       (ovf),
    .CLEAR_OVERFLOW (clr),
    .SAMPLE_COUNT   (cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: discards remaining after enable, FIFO as a queue.
  logic [BW-1:0] m_q[$];
  bit            m_ovf;
  logic [31:0]   m_cnt;
  bit            m_active;
  int            m_discard;
  bit            m_enc_d;

  // Encode clock / ADC data generator state.
  int phase  = 0;
  int period = 4;
  int pidx   = 0;
  bit inc_mode = 1'b1;
  bit rand_period = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit next_is_cap();
    return (enc == 1'b0) && m_enc_d;
  endfunction

  task automatic start_gen();
    phase = 0;
    pidx  = 0;
    enc   = 1'b1;
    adc   = '0;
  endtask

  task automatic step();
    bit cap;
    bit rd;
    bit wr;
    bit drop;
    cap  = next_is_cap();
    rd   = (m_q.size() > 0) && s_if.SAMPLE_READY;
    wr   = 1'b0;
    drop = 1'b0;
    if (rst) begin
      m_q.delete();
      m_ovf     = 1'b0;
      m_cnt     = '0;
      m_active  = 1'b0;
      m_discard = 0;
      m_enc_d   = 1'b0;
    end else begin
      m_enc_d = enc;
      if (!en) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        m_active  = 1'b1;
        m_discard = LAT;
      end else if (cap) begin
        if (m_discard > 0) m_discard--;
        else wr = 1'b1;
      end
      if (rd) void'(m_q.pop_front());
      if (wr) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(adc);
          m_cnt++;
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("valid", 64'(s_if.SAMPLE_VALID), 64'(m_q.size() > 0));
    chk("level", 64'(lvl), 64'(m_q.size()));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("count", 64'(cnt), 64'(m_cnt));
    if (m_q.size() > 0) chk("data", 64'(s_if.SAMPLE_DATA), 64'(m_q[0]));

    phase++;
    if (phase >= period) begin
      phase = 0;
      pidx++;
      if (rand_period) period = $urandom_range(6, 2);
    end
    enc = (phase < period / 2);
    adc = inc_mode ? BW'(pidx) : {$urandom, $urandom};
  endtask

  task automatic wait_level(input string tag, input int target, input int bound);
    for (int i = 0; i < bound && lvl != LW'(target); i++) step();
    chk(tag, 64'(lvl), 64'(target));
  endtask

  task automatic wait_valid(input string tag, input int bound);
    for (int i = 0; i < bound && !s_if.SAMPLE_VALID; i++) step();
    chk(tag, 64'(s_if.SAMPLE_VALID), 64'(1));
  endtask

  task automatic wait_cap(input string tag, input int bound);
    for (int i = 0; i < bound && !next_is_cap(); i++) step();
    chk(tag, 64'(next_is_cap()), 64'(1));
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    enc = 1'b0;
    adc = '0;
    s_if.SAMPLE_READY = 1'b0;
    m_q.delete();
    m_ovf = 1'b0; m_cnt = '0; m_active = 1'b0; m_discard = 0; m_enc_d = 1'b0;

    // Reset state.
    step();
    step();
    chk("rst_data", 64'(s_if.SAMPLE_DATA), 64'(0));
    chk("rst_level", 64'(lvl), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // First kept word after the flush, then in-order 5,6,7.
    start_gen();
    en = 1'b1;
    wait_level("fill3", 3, 80);
    en = 1'b0;
    chk("first_word", 64'(s_if.SAMPLE_DATA), 64'(5));
    chk("count3", 64'(cnt), 64'(3));
    for (int i = 0; i < 8; i++) step();
    chk("kept_after_disable", 64'(lvl), 64'(3));
    s_if.SAMPLE_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain3", 64'(s_if.SAMPLE_DATA), 64'(5 + i));
      step();
    end
    chk("drained3", 64'(s_if.SAMPLE_VALID), 64'(0));
    s_if.SAMPLE_READY = 1'b0;

    // Re-enable re-flushes; then overfill with no reader.
    start_gen();
    en = 1'b1;
    wait_valid("reflush_valid", 60);
    chk("reflush_word", 64'(s_if.SAMPLE_DATA), 64'(5));
    for (int i = 0; i < 100; i++) step();
    chk("full_level", 64'(lvl), 64'(DEPTH));
    chk("full_ovf", 64'(ovf), 64'(1));
    chk("full_count", 64'(cnt), 64'(3 + DEPTH));
    en = 1'b0;
    step();
    s_if.SAMPLE_READY = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("drain16", 64'(s_if.SAMPLE_DATA), 64'(5 + i));
      step();
    end
    chk("drained16", 64'(lvl), 64'(0));
    s_if.SAMPLE_READY = 1'b0;

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear_ovf", 64'(ovf), 64'(0));

    // Full FIFO with a read on the cap cycle accepts the write.
    en = 1'b1;
    wait_level("refill", DEPTH, 200);
    chk("refill_ovf", 64'(ovf), 64'(0));
    wait_cap("cap_rw", 20);
    s_if.SAMPLE_READY = 1'b1;
    step();
    s_if.SAMPLE_READY = 1'b0;
    chk("rw_level", 64'(lvl), 64'(DEPTH));
    chk("rw_ovf", 64'(ovf), 64'(0));
    chk("rw_count", 64'(cnt), 64'(m_cnt));

    // Clear coinciding with a drop loses; clear alone wins.
    wait_cap("cap_drop", 20);
    clr = 1'b1;
    step();
    chk("clr_vs_drop", 64'(ovf), 64'(1));
    step();
    clr = 1'b0;
    chk("clr_alone", 64'(ovf), 64'(0));

    // Reset mid-run at level 7, then a full flush with ENABLE held.
    s_if.SAMPLE_READY = 1'b1;
    wait_level("drain_to7", 7, 100);
    s_if.SAMPLE_READY = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(s_if.SAMPLE_VALID), 64'(0));
    chk("mid_rst_data", 64'(s_if.SAMPLE_DATA), 64'(0));
    chk("mid_rst_level", 64'(lvl), 64'(0));
    chk("mid_rst_count", 64'(cnt), 64'(0));
    start_gen();
    wait_valid("post_rst_valid", 60);
    chk("post_rst_word", 64'(s_if.SAMPLE_DATA), 64'(5));
    chk("post_rst_count", 64'(cnt), 64'(1));

    // Randomized traffic against the model.
    inc_mode    = 1'b0;
    rand_period = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      s_if.SAMPLE_READY = ($urandom_range(99, 0) < 45);
      clr = ($urandom_range(19, 0) == 0);
      if ($urandom_range(79, 0) == 0) en = ~en;
      rst = ($urandom_range(599, 0) == 0);
      step();
    end
    rst = 1'b0;
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
